pause_dim_ctrl: RTL
===================

# pause_dim_ctrl

Parametrised pause and screen-dim controller that sits between the core's input mapper and the arcade video pipeline. It merges a user pause toggle, OSD-open pause and N masked external pause requests (high-score access, etc.) into one registered pause output. After a configurable idle time under user pause, it dims the RGB stream progressively in stepped right-shifts. It supersedes the single-source, single-step pause/dim logic in the per-core top levels.

## Interface
- `RW`, 3: red channel width
- `GW`, 3: green channel width
- `BW`, 2: blue channel width
- `NSRC`, 2: number of external pause request inputs
- `DIM_CYCLES`, 480000000: clk_sys cycles of user pause before first dim step (10 s @ 48 MHz)
- `STEP_CYCLES`, 24000000: clk_sys cycles between subsequent dim steps
- `DIM_STEPS`, 2: maximum dim level (shift amount); must satisfy 1 ≤ DIM_STEPS < min(RW,GW,BW)+1
- `clk_sys` in 1: system clock
- `reset_n` in 1: synchronous, active-low reset
- `pause_btn` in 1: user pause button, level, clk_sys domain
- `pause_req` in NSRC: external pause requests, level
- `req_mask` in NSRC: 1 = honour corresponding pause_req
- `osd_open` in 1: OSD visible
- `osd_pause_en` in 1: 1 = pause while OSD open
- `ce_pix` in 1: pixel clock enable
- `r_in`/`g_in`/`b_in` in RW/GW/BW: pixel colour
- `hbl_in`/`vbl_in` in 1: blanking
- `pause` out 1: merged pause, active-high
- `user_paused` out 1: current toggle state
- `dim_level` out $clog2(DIM_STEPS+1): current shift amount
- `r_out`/`g_out`/`b_out` out RW/GW/BW: dimmed pixel
- `hbl_out`/`vbl_out` out 1: delayed blanking

## Operation
- Button edge: `btn_q` registers `pause_btn`; edge = `pause_btn & ~btn_q`. The edge flips `user_paused`.
- `pause` is registered. Its next value is `user_paused_next | (|(pause_req & req_mask)) | (osd_open & osd_pause_en)`.
- Dim FSM states: IDLE, WAIT, STEP, HOLD.
  - IDLE: counter = 0, dim_level = 0. Moves to WAIT when user_paused becomes 1.
  - WAIT: counter counts up. At count DIM_CYCLES-1: dim_level ← 1, counter ← 0. Moves to HOLD if DIM_STEPS = 1, otherwise to STEP.
  - STEP: at count STEP_CYCLES-1: dim_level increments and counter ← 0. Moves to HOLD when dim_level reaches DIM_STEPS.
  - HOLD: counter frozen, dim_level held.
  - From any state, user_paused becoming 0 forces IDLE with dim_level ← 0 in the same cycle.
- Only user pause dims the screen. OSD and external requests pause but never start the timer and never reset it.
- Pixel path: on ce_pix, each channel out ← channel in >> dim_level (logical shift), and blanking passes through. Blank pixels are still shifted.
- Counter width is $clog2(max(DIM_CYCLES,STEP_CYCLES)). No wrap is possible because the FSM leaves each counting state at its terminal count.

## Timing
- Reset (reset_n = 0 on a clk_sys edge) clears: pause, user_paused, btn_q, dim_level, counter, all pixel and blank outputs; FSM ← IDLE. A button already held when reset releases produces no edge.
- Button edge at cycle N: user_paused = 1 and pause = 1 at N+1.
- A pause_req change at N is visible on pause at N+1. A mask change behaves the same way.
- First dim step appears DIM_CYCLES cycles after user_paused rises. Each further step follows STEP_CYCLES cycles after the previous one.
- Unpause edge at cycle N: user_paused = 0, dim_level = 0, FSM = IDLE at N+1. This takes priority over a terminal count in the same cycle.
- Pixel outputs update one ce_pix after the input and use the dim_level registered at that edge. They hold between enables.

## Structure
- Shared package `pause_pkg`: FSM state enum (IDLE, WAIT, STEP, HOLD) and the default timing constants at 48 MHz.
- One sub-module, `rgb_dimmer`: the parametrised ce_pix-registered shift stage for pixel data and blanking.

## Test plan
- Reset with `pause_btn` held high, release, hold 10 cycles → pause = 0, user_paused = 0.
- DIM_CYCLES = 20, STEP_CYCLES = 8, DIM_STEPS = 2; press button at cycle 0 → pause = 1 at 1; dim_level = 1 at 21, 2 at 29, stays 2 thereafter.
- With r_in = 3'b111 and dim_level = 2, pulse ce_pix → r_out = 3'b001 on the next cycle; with ce_pix low, r_out holds.
- pause_req = 2'b10 with req_mask = 2'b01 → pause = 0; set mask to 2'b11 → pause = 1 one cycle later, and dim_level stays 0 for 100 cycles.
- Unpause edge in the same cycle as the WAIT terminal count → dim_level stays 0, FSM IDLE, pause = 0 next cycle (no other sources active).
- osd_open = 1 with osd_pause_en = 0 → pause = 0; set osd_pause_en = 1 → pause = 1 next cycle; apply reset_n = 0 in STEP → all outputs 0 next cycle.

Source files
------------

// File: rtl/pause_pkg.sv
// Shared FSM state type and 48 MHz default timing for the pause/dim controller.
package pause_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STEP,
        HOLD
    } dim_state_e;

    localparam int unsigned CLK_SYS_HZ      = 48_000_000;
    localparam int unsigned DEF_DIM_CYCLES  = 10 * CLK_SYS_HZ;   // 10 s of user pause
    localparam int unsigned DEF_STEP_CYCLES = CLK_SYS_HZ / 2;    // 0.5 s per further step
    localparam int unsigned DEF_DIM_STEPS   = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rgb_dimmer.sv
// Pixel-enable registered RGB stage: each channel is logically right-shifted by the
// current dim level; blanking rides alongside unchanged.
module rgb_dimmer #(
    parameter int unsigned RW = 3,
    parameter int unsigned GW = 3,
    parameter int unsigned BW = 2,
    parameter int unsigned SW = 2
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          ce_i,
    input  logic [SW-1:0] shift_i,
    input  logic [RW-1:0] r_i,
    input  logic [GW-1:0] g_i,
    input  logic [BW-1:0] b_i,
    input  logic          hbl_i,
    input  logic          vbl_i,
    output logic [RW-1:0] r_o,
    output logic [GW-1:0] g_o,
    output logic [BW-1:0] b_o,
    output logic          hbl_o,
    output logic          vbl_o
);

    logic [RW-1:0] r_q;
    logic [GW-1:0] g_q;
    logic [BW-1:0] b_q;
    logic          hbl_q;
    logic          vbl_q;

    // Blank pixels are shifted too; downstream masks them anyway.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            hbl_q <= 1'b0;
            vbl_q <= 1'b0;
        end else if (ce_i) begin
            r_q   <= r_i >> shift_i;
            g_q   <= g_i >> shift_i;
            b_q   <= b_i >> shift_i;
            hbl_q <= hbl_i;
            vbl_q <= vbl_i;
        end
    end

    assign r_o   = r_q;
    assign g_o   = g_q;
    assign b_o   = b_q;
    assign hbl_o = hbl_q;
    assign vbl_o = vbl_q;

endmodule

// File: rtl/pause_dim_ctrl.sv
// Merges user, OSD and masked external pause sources into one registered pause and
// progressively dims the RGB stream after a long user pause.
//
//   state | meaning
//   IDLE  | not user-paused; counter and dim level at 0
//   WAIT  | user-paused, counting towards the first dim step
//   STEP  | counting towards the next dim step
//   HOLD  | maximum dim reached; counter frozen
module pause_dim_ctrl
    import pause_pkg::*;
#(
    parameter int unsigned RW          = 3,
    parameter int unsigned GW          = 3,
    parameter int unsigned BW          = 2,
    parameter int unsigned NSRC        = 2,
    parameter int unsigned DIM_CYCLES  = DEF_DIM_CYCLES,
    parameter int unsigned STEP_CYCLES = DEF_STEP_CYCLES,
    parameter int unsigned DIM_STEPS   = DEF_DIM_STEPS
) (
    input  logic                             clk_sys,
    input  logic                             reset_n,
    input  logic                             pause_btn,
    input  logic [NSRC-1:0]                  pause_req,
    input  logic [NSRC-1:0]                  req_mask,
    input  logic                             osd_open,
    input  logic                             osd_pause_en,
    input  logic                             ce_pix,
    input  logic [RW-1:0]                    r_in,
    input  logic [GW-1:0]                    g_in,
    input  logic [BW-1:0]                    b_in,
    input  logic                             hbl_in,
    input  logic                             vbl_in,
    output logic                             pause,
    output logic                             user_paused,
    output logic [$clog2(DIM_STEPS+1)-1:0]   dim_level,
    output logic [RW-1:0]                    r_out,
    output logic [GW-1:0]                    g_out,
    output logic [BW-1:0]                    b_out,
    output logic                             hbl_out,
    output logic                             vbl_out
);

    localparam int unsigned DLW     = $clog2(DIM_STEPS + 1);
    localparam int unsigned CNT_MAX = max_u(DIM_CYCLES, STEP_CYCLES);
    localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CW-1:0]  DIM_TC  = CW'(DIM_CYCLES - 1);
    localparam logic [CW-1:0]  STEP_TC = CW'(STEP_CYCLES - 1);
    localparam logic [DLW-1:0] DIM_MAX = DLW'(DIM_STEPS);

    logic           btn_q;
    logic           arm_q;
    logic           btn_edge;
    logic           user_paused_q, user_paused_d;
    logic           pause_q, pause_d;
    dim_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DLW-1:0] dim_q, dim_d;

    // arm_q blocks the first post-reset cycle so a button held through reset is not an edge.
    assign btn_edge      = pause_btn & ~btn_q & arm_q;
    assign user_paused_d = user_paused_q ^ btn_edge;
    assign pause_d       = user_paused_d | (|(pause_req & req_mask)) | (osd_open & osd_pause_en);

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            btn_q         <= 1'b0;
            arm_q         <= 1'b0;
            user_paused_q <= 1'b0;
            pause_q       <= 1'b0;
            state_q       <= IDLE;
            cnt_q         <= '0;
            dim_q         <= '0;
        end else begin
            btn_q         <= pause_btn;
            arm_q         <= 1'b1;
            user_paused_q <= user_paused_d;
            pause_q       <= pause_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            dim_q         <= dim_d;
        end
    end

    // Unpause overrides everything, including a terminal count in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dim_d   = dim_q;
        if (!user_paused_d) begin
            state_d = IDLE;
            cnt_d   = '0;
            dim_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    dim_d   = '0;
                end
                WAIT: begin
                    if (cnt_q == DIM_TC) begin
                        dim_d   = DLW'(1);
                        cnt_d   = '0;
                        state_d = (DIM_STEPS == 1) ? HOLD : STEP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STEP: begin
                    if (cnt_q == STEP_TC) begin
                        dim_d = dim_q + DLW'(1);
                        cnt_d = '0;
                        if (dim_d == DIM_MAX) begin
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                HOLD: begin
                    state_d = HOLD;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dim_d   = '0;
                end
            endcase
        end
    end

    assign pause       = pause_q;
    assign user_paused = user_paused_q;
    assign dim_level   = dim_q;

    rgb_dimmer #(
        .RW (RW),
        .GW (GW),
        .BW (BW),
        .SW (DLW)
    ) u_rgb_dimmer (
        .clk_i   (clk_sys),
        .rst_n_i (reset_n),
        .ce_i    (ce_pix),
        .shift_i (dim_q),
        .r_i     (r_in),
        .g_i     (g_in),
        .b_i     (b_in),
        .hbl_i   (hbl_in),
        .vbl_i   (vbl_in),
        .r_o     (r_out),
        .g_o     (g_out),
        .b_o     (b_out),
        .hbl_o   (hbl_out),
        .vbl_o   (vbl_out)
    );

endmodule
